ef_smsdac_feeder: RTL and testbench

Sample-feed stage directly upstream of the segmented mismatch-shaping DAC top. It receives 8-bit unsigned samples over a 3-wire SPI-style serial port, which it oversamples in the system clock domain, and buffers them in a small FIFO. At a programmable sample rate it releases one sample per tick onto the parallel bus that drives the DAC d_in. Underrun and overflow are flagged sticky so firmware can detect rate mismatch.

---
 rtl/ef_smsdac_feeder.sv | 139 +++++++++++++
 tb/tb_ef_smsdac_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_smsdac_feeder.sv
// Serial-to-parallel sample feeder for the segmented mismatch-shaping DAC.
// Oversamples a 3-wire serial port, buffers bytes in a FIFO and releases one per divider tick.
module ef_smsdac_feeder #(
  parameter int DEPTH         = 4,
  parameter int DIV_W         = 8,
  parameter int UNDERRUN_HOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       sclk,
  input  logic                       cs_b,
  input  logic                       mosi,
  input  logic                       run,
  input  logic [DIV_W-1:0]           div,
  input  logic                       clr_flags,
  output logic [7:0]                 d_out,
  output logic                       sample_stb,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underrun,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Handshake: a push is accepted whenever the FIFO has room or a pop frees a slot
  // on the same edge; a pop happens only on a divider tick with the FIFO non-empty.

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;

  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [DIV_W-1:0] cnt;

  logic       sclk_rise;
  logic       push, push_ok, pop, tick;
  logic       empty, full;
  logic [7:0] push_data;
  logic [AW:0] count;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign push      = ~cs_s2 & sclk_rise & (bit_cnt == 3'd7);
  assign push_data = {shift[6:0], mosi_s2};

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign tick    = run & (cnt == div);
  assign pop     = tick & ~empty;
  assign push_ok = push & (~full | pop);

  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs_b;
      cs_s2   <= cs_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // A deasserted chip-select throws away any partial byte.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else if (cs_s2) begin
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else if (sclk_rise) begin
      shift   <= {shift[6:0], mosi_s2};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b)    cnt <= '0;
    else if (!run) cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      d_out      <= 8'h80;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= pop;
      if (pop)
        d_out <= mem[rd_ptr[AW-1:0]];
      else if (tick && (UNDERRUN_HOLD == 0))
        d_out <= 8'h80;
    end
  end

  // Setting a flag wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (tick && empty)           underrun <= 1'b1;
      else if (clr_flags)          underrun <= 1'b0;
      if (push && full && !pop)    overflow <= 1'b1;
      else if (clr_flags)          overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ef_smsdac_feeder.sv
// Bench for ef_smsdac_feeder: directed serial traffic, a queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_ef_smsdac_feeder;

  localparam int DEPTH         = 4;
  localparam int DIV_W         = 8;
  localparam int UNDERRUN_HOLD = 1;

  logic             clk = 1'b0;
  logic             rst_b, sclk, cs_b, mosi, run, clr_flags;
  logic [DIV_W-1:0] div;
  logic [7:0]       d_out;
  logic             sample_stb;
  logic [2:0]       fifo_level;
  logic             underrun, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit model_valid = 1'b0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } pend_t;

  pend_t      pend_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_dout;
  logic       m_stb, m_und, m_ovf;
  int         m_cnt;

  logic [7:0] pop_v[$];
  int         pop_c[$];
  bit         saw_lvl1;

  ef_smsdac_feeder #(.DEPTH(DEPTH), .DIV_W(DIV_W), .UNDERRUN_HOLD(UNDERRUN_HOLD)) dut (
    .clk(clk), .rst_b(rst_b), .sclk(sclk), .cs_b(cs_b), .mosi(mosi),
    .run(run), .div(div), .clr_flags(clr_flags),
    .d_out(d_out), .sample_stb(sample_stb), .fifo_level(fifo_level),
    .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a byte queue fed by the serial driver three edges after the final sclk rise.
  always @(posedge clk) begin : model
    bit         tick, pop, push, empty_pre, full_pre;
    logic [7:0] pdata;
    cyc++;
    push  = 1'b0;
    pdata = 8'h00;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      push  = 1'b1;
      pdata = pend_q[0].data;
      pend_q.delete(0);
    end
    if (!rst_b) begin
      exp_q.delete();
      pend_q.delete();
      m_dout = 8'h80;
      m_stb  = 1'b0;
      m_und  = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
      model_valid = 1'b1;
    end else begin
      tick      = run && (m_cnt == int'(div));
      m_cnt     = (!run || tick) ? 0 : (m_cnt + 1) % (1 << DIV_W);
      empty_pre = (exp_q.size() == 0);
      full_pre  = (exp_q.size() == DEPTH);
      pop       = tick && !empty_pre;
      m_stb     = pop;
      if (pop) m_dout = exp_q.pop_front();
      else if (tick && UNDERRUN_HOLD == 0) m_dout = 8'h80;
      if (tick && empty_pre) m_und = 1'b1;
      else if (clr_flags)    m_und = 1'b0;
      if (push && full_pre && !pop) m_ovf = 1'b1;
      else begin
        if (push) exp_q.push_back(pdata);
        if (clr_flags) m_ovf = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("d_out",      32'(d_out),      32'(m_dout));
      chk("sample_stb", 32'(sample_stb), 32'(m_stb));
      chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("underrun",   32'(underrun),   32'(m_und));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      if (sample_stb === 1'b1) begin
        pop_v.push_back(d_out);
        pop_c.push_back(cyc);
      end
      if (fifo_level == 3'd1) saw_lvl1 = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      sclk = 1'b0;
      repeat (4) step();
      sclk = 1'b1;
      if (i == 7) pend_q.push_back('{due: cyc + 3, data: b});
      repeat (4) step();
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_b = 1'b0;
    repeat (4) step();
  endtask

  task automatic frame_end();
    repeat (2) step();
    cs_b = 1'b1;
    repeat (6) step();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  task automatic clear_log();
    pop_v.delete();
    pop_c.delete();
    saw_lvl1 = 1'b0;
  endtask

  initial begin
    logic [7:0] vals[4];
    rst_b = 1'b0; sclk = 1'b0; cs_b = 1'b1; mosi = 1'b0;
    run = 1'b0; div = '0; clr_flags = 1'b0;

    // Reset with the serial port toggling.
    for (int i = 0; i < 3; i++) begin
      step();
      sclk = ~sclk; mosi = ~mosi; cs_b = ~cs_b;
    end
    chk("rst_d_out", 32'(d_out), 32'h80);
    chk("rst_stb",   32'(sample_stb), 0);
    chk("rst_under", 32'(underrun), 0);
    chk("rst_over",  32'(overflow), 0);
    chk("rst_level", 32'(fifo_level), 0);
    rst_b = 1'b1; sclk = 1'b0; cs_b = 1'b1; mosi = 1'b0;
    repeat (4) step();
    chk("rst_no_push", 32'(fifo_level), 0);

    // Single byte with the divider running.
    div = 8'd3; run = 1'b1;
    clear_log();
    frame_start();
    send_bits(8'hA5, 8);
    frame_end();
    repeat (4) step();
    chk("one_saw_lvl1", 32'(saw_lvl1), 1);
    chk("one_pops",     32'(pop_v.size()), 1);
    if (pop_v.size() > 0) chk("one_value", 32'(pop_v[0]), 32'hA5);
    chk("one_level0",   32'(fifo_level), 0);

    // Five bytes into a four-deep FIFO, then drain at div=3.
    run = 1'b0;
    step();
    pulse_clr();
    frame_start();
    for (int i = 1; i <= 5; i++) send_bits(8'(i), 8);
    frame_end();
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_under", 32'(underrun), 0);
    clear_log();
    div = 8'd3; run = 1'b1;
    repeat (24) step();
    chk("drain_pops", 32'(pop_v.size()), 4);
    for (int i = 0; i < 4 && i < pop_v.size(); i++)
      chk("drain_value", 32'(pop_v[i]), 32'(i + 1));
    for (int i = 0; i < 3 && i + 1 < pop_c.size(); i++)
      chk("drain_spacing", 32'(pop_c[i+1] - pop_c[i]), 4);
    chk("drain_under", 32'(underrun), 1);
    chk("drain_hold",  32'(d_out), 32'h04);

    // Aborted partial byte followed by a full byte.
    run = 1'b0;
    step();
    pulse_clr();
    frame_start();
    send_bits(8'hFF, 5);
    frame_end();
    chk("abort_level", 32'(fifo_level), 0);
    frame_start();
    send_bits(8'h3C, 8);
    frame_end();
    chk("abort_one_push", 32'(fifo_level), 1);
    clear_log();
    run = 1'b1;
    repeat (8) step();
    chk("abort_pops",  32'(pop_v.size()), 1);
    if (pop_v.size() > 0) chk("abort_value", 32'(pop_v[0]), 32'h3C);

    // div=0 burst from a full FIFO; clear collides with underrun.
    run = 1'b0;
    step();
    pulse_clr();
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    frame_start();
    for (int i = 0; i < 4; i++) send_bits(vals[i], 8);
    frame_end();
    chk("burst_level", 32'(fifo_level), 4);
    chk("burst_under0", 32'(underrun), 0);
    div = 8'd0; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("burst_stb",   32'(sample_stb), 1);
      chk("burst_value", 32'(d_out), 32'(vals[i]));
      if (i == 3) clr_flags = 1'b1;
    end
    step();
    clr_flags = 1'b0;
    chk("burst_stb_end",   32'(sample_stb), 0);
    chk("burst_set_wins",  32'(underrun), 1);
    chk("burst_hold",      32'(d_out), 32'h44);

    // Reset mid-byte with two bytes buffered.
    run = 1'b0;
    step();
    pulse_clr();
    frame_start();
    send_bits(8'hDE, 8);
    send_bits(8'hAD, 8);
    send_bits(8'h77, 5);
    chk("mid_level", 32'(fifo_level), 2);
    rst_b = 1'b0;
    repeat (3) step();
    chk("mid_rst_d_out", 32'(d_out), 32'h80);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_stb",   32'(sample_stb), 0);
    chk("mid_rst_over",  32'(overflow), 0);
    rst_b = 1'b1; cs_b = 1'b1; sclk = 1'b0;
    step();
    clear_log();
    div = 8'd1; run = 1'b1;
    repeat (20) step();
    chk("mid_no_pops",  32'(pop_v.size()), 0);
    chk("mid_under",    32'(underrun), 1);
    chk("mid_level0",   32'(fifo_level), 0);
    chk("mid_d_out",    32'(d_out), 32'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
